tube_display_arbiter: RTL and testbench

TUBE_DISPLAY_ARBITER -- requirements
Module: tube_display_arbiter

---
 rtl/tube_display_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_tube_display_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tube_display_arbiter.sv
// Two-requester round-robin arbiter for the scan-tube display with a minimum hold time per grant.
// Latency: one cycle from a sampled request to registered grant/disp_data/disp_valid.
// No backpressure: requesters hold req high while they want the display; ownership changes only at hold expiry.
module tube_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned DW          = 10
) (
    input  logic          clk_50M,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    output logic [1:0]    grant,
    output logic [DW-1:0] disp_data,
    output logic          disp_valid,
    output logic          busy
);

    // The hold counter only ever needs to reach HOLD_CYCLES-1, where it saturates.
    localparam int unsigned    CW     = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0]  C_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_rr;
    logic          r_owner;
    logic [1:0]    r_grant;
    logic [DW-1:0] r_disp_data;
    logic          r_disp_valid;
    logic          r_busy;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_rr_nxt;
    logic          w_owner_nxt;
    logic [1:0]    w_grant_nxt;
    logic [DW-1:0] w_data_nxt;
    logic          w_valid_nxt;

    logic          w_expired;
    logic          w_owner_req;
    logic          w_other_req;
    logic [DW-1:0] w_owner_data;
    logic [DW-1:0] w_other_data;
    logic          w_idle_winner;

    function automatic logic [1:0] f_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Decode the current owner's view of the inputs and the IDLE tie-break.
    always_comb begin
        w_expired     = (r_cnt == C_LAST);
        w_owner_req   = req[r_owner];
        w_other_req   = req[~r_owner];
        w_owner_data  = r_owner ? data1 : data0;
        w_other_data  = r_owner ? data0 : data1;
        // A lone requester wins outright; only a tie consults the pointer.
        case (req)
            2'b01:   w_idle_winner = 1'b0;
            2'b10:   w_idle_winner = 1'b1;
            default: w_idle_winner = r_rr;
        endcase
    end

    // Next-state and next-output logic; everything holds unless a branch says otherwise.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr;
        w_owner_nxt = r_owner;
        w_grant_nxt = r_grant;
        w_data_nxt  = r_disp_data;
        w_valid_nxt = r_disp_valid;

        case (r_state)
            S_IDLE: begin
                // disp_data keeps the last shown value while nobody owns the tube.
                w_grant_nxt = 2'b00;
                w_valid_nxt = 1'b0;
                if (req != 2'b00) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_idle_winner;
                    w_rr_nxt    = ~w_idle_winner;
                    w_cnt_nxt   = '0;
                    w_grant_nxt = f_onehot(w_idle_winner);
                    w_data_nxt  = w_idle_winner ? data1 : data0;
                    w_valid_nxt = 1'b1;
                end
            end

            S_GRANT, S_HOLD: begin
                if (w_expired) begin
                    // Minimum hold is met: the other side takes over if it asks,
                    // otherwise the owner may keep the tube in a saturated grant.
                    if (w_other_req) begin
                        w_state_nxt = S_GRANT;
                        w_owner_nxt = ~r_owner;
                        w_rr_nxt    = r_owner;
                        w_cnt_nxt   = '0;
                        w_grant_nxt = f_onehot(~r_owner);
                        w_data_nxt  = w_other_data;
                        w_valid_nxt = 1'b1;
                    end else if (w_owner_req) begin
                        w_state_nxt = S_GRANT;
                        w_grant_nxt = f_onehot(r_owner);
                        w_data_nxt  = w_owner_data;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_grant_nxt = 2'b00;
                        w_valid_nxt = 1'b0;
                    end
                end else if ((r_state == S_GRANT) && w_owner_req) begin
                    // Live ownership: follow the owner's data every cycle.
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_grant_nxt = f_onehot(r_owner);
                    w_data_nxt  = w_owner_data;
                    w_valid_nxt = 1'b1;
                end else begin
                    // Owner let go early (or is already holding): freeze the
                    // display and run out the remaining hold time. A re-raised
                    // owner request does not end HOLD early.
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = r_cnt + CW'(1);
                    w_grant_nxt = 2'b00;
                    w_valid_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_grant_nxt = 2'b00;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State register; reset wins over every other input in the same edge.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered arbitration bookkeeping and display outputs.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_cnt        <= '0;
            r_rr         <= 1'b0;
            r_owner      <= 1'b0;
            r_grant      <= 2'b00;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_rr         <= w_rr_nxt;
            r_owner      <= w_owner_nxt;
            r_grant      <= w_grant_nxt;
            r_disp_data  <= w_data_nxt;
            r_disp_valid <= w_valid_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign grant      = r_grant;
    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_tube_display_arbiter.sv
// Bench for tube_display_arbiter with a 4-cycle hold time.
// Directed table of vectors, a hand-written saturated-grant takeover, then random traffic against a model.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_tube_display_arbiter;

    localparam int HOLD = 4;
    localparam int DW   = 10;

    logic          clk_50M = 1'b0;
    logic          rst     = 1'b1;
    logic [1:0]    req     = 2'b00;
    logic [DW-1:0] data0   = '0;
    logic [DW-1:0] data1   = '0;
    logic [1:0]    grant;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          busy;

    int n_vec = 0;
    int n_bad = 0;

    tube_display_arbiter #(
        .HOLD_CYCLES (HOLD),
        .DW          (DW)
    ) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .grant      (grant),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .busy       (busy)
    );

    always #5 clk_50M = ~clk_50M;

    // Reference model: owner index (-1 = nobody), cycles elapsed since the grant,
    // whether the owner has let go, and the value on the tube.
    int            m_owner   = -1;
    int            m_elapsed = 0;
    bit            m_hold    = 1'b0;
    logic [DW-1:0] m_shown   = '0;
    int            m_rr      = 0;

    task automatic model_start(input int w, input logic [DW-1:0] a, input logic [DW-1:0] b);
        m_owner   = w;
        m_elapsed = 0;
        m_hold    = 1'b0;
        m_shown   = (w == 1) ? b : a;
        m_rr      = 1 - w;
    endtask

    task automatic model_edge(input logic r, input logic [1:0] rq,
                              input logic [DW-1:0] a, input logic [DW-1:0] b);
        int oth;
        if (r) begin
            m_owner = -1; m_elapsed = 0; m_hold = 1'b0; m_shown = '0; m_rr = 0;
        end else if (m_owner < 0) begin
            if (rq == 2'b11)      model_start(m_rr, a, b);
            else if (rq == 2'b01) model_start(0, a, b);
            else if (rq == 2'b10) model_start(1, a, b);
        end else begin
            oth = 1 - m_owner;
            if (m_elapsed >= HOLD - 1) begin
                if (rq[oth]) begin
                    model_start(oth, a, b);
                end else if (rq[m_owner]) begin
                    m_hold  = 1'b0;
                    m_shown = (m_owner == 1) ? b : a;
                end else begin
                    m_owner = -1;
                    m_hold  = 1'b0;
                end
            end else begin
                if (!m_hold && rq[m_owner]) m_shown = (m_owner == 1) ? b : a;
                else                        m_hold  = 1'b1;
                m_elapsed++;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, and land 1 unit after the edge.
    task automatic apply(input logic r, input logic [1:0] rq,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        rst = r; req = rq; data0 = a; data1 = b;
        model_edge(r, rq, a, b);
        @(posedge clk_50M);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] eg, input logic [DW-1:0] ed,
                         input logic ev, input logic eb);
        n_vec++;
        if (grant !== eg || disp_data !== ed || disp_valid !== ev || busy !== eb) begin
            n_bad++;
            $display("FAIL %s: got grant=%b data=%0d valid=%b busy=%b, want grant=%b data=%0d valid=%b busy=%b",
                     tag, grant, disp_data, disp_valid, busy, eg, ed, ev, eb);
        end
    endtask

    task automatic check_model(input string tag);
        logic [1:0] eg;
        eg = 2'b00;
        if (m_owner >= 0 && !m_hold) eg = (m_owner == 1) ? 2'b10 : 2'b01;
        check(tag, eg, m_shown, (m_owner >= 0), (m_owner >= 0));
    endtask

    typedef struct {
        logic          rst;
        logic [1:0]    req;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [1:0]    g;
        logic [DW-1:0] dd;
        logic          v;
        logic          b;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [1:0] rq, input int a, input int b,
                       input logic [1:0] g, input int dd, input logic v, input logic bz);
        vec_t t;
        t.rst = r; t.req = rq; t.d0 = DW'(a); t.d1 = DW'(b);
        t.g = g; t.dd = DW'(dd); t.v = v; t.b = bz;
        tbl.push_back(t);
    endtask

    initial begin
        int hold_len;
        logic [1:0] cur_req;
        string tag;

        // Reset, and reset ignoring requests.
        add(1, 2'b00,   0,   0, 2'b00,   0, 0, 0);
        add(1, 2'b11,   5,   6, 2'b00,   0, 0, 0);
        // Single request granted in one cycle, data tracks the owner.
        add(0, 2'b01, 123,   7, 2'b01, 123, 1, 1);
        add(0, 2'b01, 456,   7, 2'b01, 456, 1, 1);
        // Owner drops early: frozen hold runs out, then idle keeps the value.
        add(0, 2'b00, 456,   7, 2'b00, 456, 1, 1);
        add(0, 2'b00, 999,   8, 2'b00, 456, 1, 1);
        add(0, 2'b00, 999,   8, 2'b00, 456, 0, 0);
        add(0, 2'b00,   1,   2, 2'b00, 456, 0, 0);
        // Owner 0 drops after 1 cycle, re-raises during HOLD without effect.
        add(0, 2'b01,  77,   3, 2'b01,  77, 1, 1);
        add(0, 2'b00,  78,   3, 2'b00,  77, 1, 1);
        add(0, 2'b01,  79,   3, 2'b00,  77, 1, 1);
        add(0, 2'b00,  80,   3, 2'b00,  77, 1, 1);
        add(0, 2'b00,  81,   3, 2'b00,  77, 0, 0);
        // Reset clears the display, then contention alternates every 4 cycles.
        add(1, 2'b00,  81,   3, 2'b00,   0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            logic [1:0] g;
            g = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
            add(0, 2'b11, 10 + i, 20 + i, g, (g == 2'b01) ? 10 + i : 20 + i, 1, 1);
        end
        // Owner 1 drops, then reset lands mid-HOLD; a fresh request gets a full hold.
        add(0, 2'b00,   0,  40, 2'b00,  32, 1, 1);
        add(1, 2'b00,   0,  41, 2'b00,   0, 0, 0);
        add(0, 2'b10,   1, 100, 2'b10, 100, 1, 1);
        add(0, 2'b10,   2, 101, 2'b10, 101, 1, 1);
        add(0, 2'b00,   3, 102, 2'b00, 101, 1, 1);
        add(0, 2'b00,   4, 103, 2'b00, 101, 1, 1);
        add(0, 2'b00,   5, 104, 2'b00, 101, 0, 0);

        #1;
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].req, tbl[i].d0, tbl[i].d1);
            tag = $sformatf("vec%0d", i);
            check(tag, tbl[i].g, tbl[i].dd, tbl[i].v, tbl[i].b);
        end

        // Saturated grant for owner 0, then requester 1 takes over on the first edge it is seen.
        for (int i = 0; i < 8; i++) begin
            apply(0, 2'b01, DW'(50 + i), DW'(300 + i));
            check("sat_own0", 2'b01, DW'(50 + i), 1'b1, 1'b1);
        end
        apply(0, 2'b11, 10'd60, 10'd200);
        check("sat_takeover", 2'b10, 10'd200, 1'b1, 1'b1);
        apply(0, 2'b11, 10'd61, 10'd201);
        check("sat_nonowner_data", 2'b10, 10'd201, 1'b1, 1'b1);

        // Random traffic against the model, with bursty request patterns and rare resets.
        apply(1, 2'b00, '0, '0);
        check_model("rand_reset");
        hold_len = 0;
        cur_req  = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            logic r;
            if (hold_len == 0) begin
                cur_req  = 2'($urandom_range(0, 3));
                hold_len = $urandom_range(1, 10);
            end
            hold_len--;
            r = ($urandom_range(0, 199) == 0);
            apply(r, cur_req, DW'($urandom), DW'($urandom));
            check_model("rand");
            if (grant == 2'b11) begin
                n_bad++;
                $display("FAIL onehot: got grant=%b, want at most one bit set", grant);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
